// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, a 2-entry
// prefetch FIFO toward the decoder, and redirect handling that drops stale responses.
module fetch_unit #(
  parameter int                          RISCV_ADDR_WIDTH = 32,
  parameter int                          RISCV_WORD_WIDTH = 32,
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR        = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
  input  logic                        jump_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] jump_target_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i
);

  localparam int AW = RISCV_ADDR_WIDTH;
  localparam int WW = RISCV_WORD_WIDTH;
  localparam logic [AW-1:0] PC_STEP    = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [AW-1:0] inflight_q, inflight_d;
  logic          held_q, held_d;
  logic          discard_q, discard_d;

  logic [WW-1:0] fifo_instr_q [2];
  logic [AW-1:0] fifo_addr_q  [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  logic [1:0]    occupancy_s;
  logic          req_s, gnt_s, push_s, pop_s;
  logic [AW-1:0] req_addr_s;

  // A pending discard reserves a FIFO slot, so an accepted response always fits.
  always_comb begin
    occupancy_s = count_q + {1'b0, discard_q};
    req_s       = (state_q == REQ) && (held_q || (occupancy_s < 2'd2));
    req_addr_s  = held_q ? hold_addr_q : pc_q;
    gnt_s       = req_s && imem_gnt_i;
    push_s      = (state_q == WAIT) && imem_rvalid_i && !discard_q && !jump_i;
    pop_s       = (count_q != 2'd0) && instr_ready_i && !jump_i;
  end

  // Next-state logic for the request FSM, pc and discard tracking.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    held_d      = held_q;
    hold_addr_d = hold_addr_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;

    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = gnt_s ? WAIT : REQ;
      WAIT:    state_d = imem_rvalid_i ? REQ : WAIT;
      default: state_d = IDLE;
    endcase

    if (gnt_s) begin
      held_d     = 1'b0;
      inflight_d = req_addr_s;
    end else if (req_s) begin
      held_d      = 1'b1;
      hold_addr_d = req_addr_s;
    end else begin
      held_d = held_q;
    end

    // A redirect taken while a request was held already moved pc to the target.
    if (jump_i) begin
      pc_d = jump_target_i & ALIGN_MASK;
    end else if (gnt_s && !discard_q) begin
      pc_d = req_addr_s + PC_STEP;
    end else begin
      pc_d = pc_q;
    end

    if ((state_q == WAIT) && imem_rvalid_i) begin
      discard_d = 1'b0;
    end else if (jump_i && ((state_q == WAIT) || req_s)) begin
      discard_d = 1'b1;
    end else begin
      discard_d = discard_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= BOOT_ADDR;
      held_q      <= 1'b0;
      hold_addr_q <= BOOT_ADDR;
      inflight_q  <= BOOT_ADDR;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      held_q      <= held_d;
      hold_addr_q <= hold_addr_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
    end
  end

  // Prefetch FIFO; a redirect flushes it and suppresses any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (jump_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
        fifo_addr_q[wr_ptr_q]  <= inflight_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  assign imem_req_o    = req_s;
  assign imem_addr_o   = req_addr_s;
  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = fifo_instr_q[rd_ptr_q];
  assign instr_addr_o  = fifo_addr_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory/decoder/redirect traffic against a
// redirect-aware reference stream, plus directed scenarios and a wrap-around instance.
module tb_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        jump_i, instr_valid_o, instr_ready_i;
  logic [31:0] jump_target_i, instr_o, instr_addr_o;

  logic        w_req, w_gnt, w_rv, w_valid;
  logic [31:0] w_addr, w_instr, w_iaddr;

  always #5 clk = ~clk;

  fetch_unit #(.BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i)
  );

  fetch_unit #(.BOOT_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rv), .imem_rdata_i(32'h0000_0013),
    .jump_i(1'b0), .jump_target_i(32'h0000_0000),
    .instr_o(w_instr), .instr_addr_o(w_iaddr),
    .instr_valid_o(w_valid), .instr_ready_i(1'b1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Memory responder: one outstanding grant, configurable grant rate and latency.
  bit          gnt_block = 1'b0;
  int          lat_fixed = 1;
  int          gnt_pct   = 100;
  bit          mem_out   = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt;

  initial begin
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
      if (mem_out) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(mem_addr);
          mem_out       = 1'b0;
        end
      end else if (imem_req_o && !gnt_block && (int'($urandom_range(99)) < gnt_pct)) begin
        imem_gnt_i = 1'b1;
        mem_out    = 1'b1;
        mem_addr   = imem_addr_o;
        mem_cnt    = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(3, 1));
      end
    end
  end

  // Reference model: sequential fetch stream, redirects restart it and kill older responses.
  logic [63:0] exp_q[$];
  logic [31:0] m_exp_addr = BOOT, m_cur_addr = BOOT, m_inf_addr = BOOT;
  bit          m_held = 1'b0, m_dirty = 1'b0, m_live = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_exp_addr = BOOT; m_held = 1'b0; m_dirty = 1'b0; m_live = 1'b0;
        exp_q.delete();
      end else begin
        if (imem_rvalid_i) begin
          if (m_live && !jump_i) exp_q.push_back({mem_word(m_inf_addr), m_inf_addr});
          m_live = 1'b0;
        end
        if (m_held) chk("req_held", {31'b0, imem_req_o}, 32'd1);
        if (imem_req_o) begin
          if (m_held) chk("addr_held", imem_addr_o, m_cur_addr);
          else begin
            chk("req_addr", imem_addr_o, m_exp_addr);
            m_cur_addr = m_exp_addr;
          end
          if (imem_gnt_i) begin
            m_inf_addr = m_cur_addr;
            m_live     = !m_dirty && !jump_i;
            if (!m_dirty) m_exp_addr = m_cur_addr + 32'd4;
            m_dirty = 1'b0;
            m_held  = 1'b0;
          end else begin
            m_held = 1'b1;
            if (jump_i) m_dirty = 1'b1;
          end
        end else begin
          m_held = 1'b0;
        end
        if (jump_i) begin
          m_exp_addr = jump_target_i & 32'hFFFF_FFFC;
          m_live     = 1'b0;
          exp_q.delete();
        end
      end
    end
  end

  // Monitor: every decoder transfer must match the oldest surviving expected word.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid_o && instr_ready_i && !jump_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_instr: got addr %h, expected no instruction", instr_addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr_o, e[63:32]);
          chk("instr_addr", instr_addr_o, e[31:0]);
        end
      end
    end
  end

  // Wrap-around instance: always granted, 1-cycle latency.
  bit          w_done = 1'b0;
  initial begin
    logic [31:0] w_addrs [2];
    int          n = 0;
    bit          w_seen = 1'b0, w_g;
    w_gnt = 1'b1; w_rv = 1'b0;
    w_addrs[0] = 32'h0; w_addrs[1] = 32'h1;
    @(posedge rst_n);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (w_valid && !w_seen) begin
        chk("wrap_first_instr_addr", w_iaddr, 32'hFFFF_FFFC);
        w_seen = 1'b1;
      end
      w_g = w_req;
      if (w_req && n < 2) begin w_addrs[n] = w_addr; n++; end
      @(posedge clk); #1 w_rv = w_g;
    end
    w_rv = 1'b0;
    chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", w_addrs[1], 32'h0000_0000);
    chk("wrap_instr_seen", {31'b0, w_seen}, 32'd1);
    w_done = 1'b1;
  end

  // Main stimulus.
  initial begin
    bit          found;
    logic [31:0] old_a;
    rst_n = 1'b0; jump_i = 1'b0; jump_target_i = 32'h0; instr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, BOOT);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instr_addr", instr_addr_o, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // First fetch: response visible one cycle after rvalid.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_rvalid_i) found = 1'b1;
    end
    chk("first_rvalid_timeout", {31'b0, found}, 32'd1);
    @(negedge clk);
    chk("no_comb_rvalid_path", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("first_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("first_instr", instr_o, 32'h0000_0013);
    chk("first_instr_addr", instr_addr_o, 32'h0);

    // Decoder stalled: FIFO fills with 0 and 4, requests stop.
    repeat (10) @(negedge clk);
    chk("full_no_req", {31'b0, imem_req_o}, 32'd0);
    chk("full_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("full_head_stable", instr_addr_o, 32'h0);
    @(posedge clk); #2 instr_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_head0", instr_addr_o, 32'h0);
    @(negedge clk);
    chk("drain_head1", instr_addr_o, 32'h4);
    repeat (6) @(negedge clk);

    // Redirect while the request is held without grant.
    gnt_block = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_req_o && !mem_out) found = 1'b1;
    end
    chk("held_req_timeout", {31'b0, found}, 32'd1);
    old_a = imem_addr_o;
    jump_i = 1'b1; jump_target_i = 32'h0000_0100;
    @(posedge clk); #2 jump_i = 1'b0;
    @(negedge clk);
    chk("held_addr_after_jump", imem_addr_o, old_a);
    chk("held_req_after_jump", {31'b0, imem_req_o}, 32'd1);
    @(posedge clk); #2 gnt_block = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid_o) found = 1'b1;
    end
    chk("redirect_valid_timeout", {31'b0, found}, 32'd1);
    chk("redirect_instr_addr", instr_addr_o, 32'h0000_0100);

    // Redirect coinciding with rvalid.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_rvalid_i) found = 1'b1;
    end
    chk("rvalid_jump_timeout", {31'b0, found}, 32'd1);
    jump_i = 1'b1; jump_target_i = 32'h0000_0203;
    @(posedge clk); #2 jump_i = 1'b0;
    @(negedge clk);
    chk("rvalid_jump_flushed", {31'b0, instr_valid_o}, 32'd0);
    chk("rvalid_jump_req", {31'b0, imem_req_o}, 32'd1);
    chk("rvalid_jump_addr", imem_addr_o, 32'h0000_0200);
    repeat (6) @(negedge clk);

    // Reset pulse while a response is outstanding.
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_req_o && imem_gnt_i) found = 1'b1;
    end
    chk("rst_wait_gnt_timeout", {31'b0, found}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid0", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("midrst_req", {31'b0, imem_req_o}, 32'd1);
    chk("midrst_addr", imem_addr_o, BOOT);
    @(negedge clk);
    chk("midrst_stale_dropped", {31'b0, instr_valid_o}, 32'd0);

    // Random traffic.
    lat_fixed = 0; gnt_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      instr_ready_i = (int'($urandom_range(99)) < 70);
      jump_i        = (int'($urandom_range(99)) < 4);
      jump_target_i = $urandom;
    end
    @(posedge clk); #2 jump_i = 1'b0; instr_ready_i = 1'b1;
    repeat (30) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (w_done) found = 1'b1;
    end
    chk("wrap_done_timeout", {31'b0, found}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req_o  output  1  instruction memory request.
REQ-005 imem_addr_o  output  RISCV_ADDR_WIDTH  request address, word-aligned.
REQ-006 imem_gnt_i  input  1  request accepted this cycle when imem_req_o=1.
REQ-007 imem_rvalid_i  input  1  read data valid (exactly one per grant, earliest 1 cycle after gnt).
REQ-008 imem_rdata_i  input  RISCV_WORD_WIDTH  fetched instruction word.
REQ-009 jump_i  input  1  redirect strobe from execute.
REQ-010 jump_target_i  input  RISCV_ADDR_WIDTH  redirect address; bits [1:0] ignored (treated as 0).
REQ-011 instr_o  output  RISCV_WORD_WIDTH  instruction to decoder.
REQ-012 instr_addr_o  output  RISCV_ADDR_WIDTH  address of instr_o.
REQ-013 instr_valid_o  output  1  instr_o/instr_addr_o valid.
REQ-014 instr_ready_i  input  1  decoder accepts; transfer when instr_valid_o & instr_ready_i.

Function
REQ-015 FSM states IDLE, REQ, WAIT; plus pc register, 2-entry FIFO of {instr, addr}, one-bit discard flag.
REQ-016 IDLE -> REQ unconditionally on first clk edge after reset release; IDLE never re-entered except by reset.
REQ-017 In REQ: imem_req_o=1 iff (fifo_count + discard) < 2 or a request is already being held; imem_addr_o=pc.
REQ-018 Once imem_req_o=1, imem_req_o and imem_addr_o SHALL stay constant until the cycle imem_gnt_i=1, even if jump_i occurs.
REQ-019 REQ with gnt -> WAIT, latch request address as inflight_addr; pc <= pc+4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-020 WAIT with rvalid: if discard=0, push {imem_rdata_i, inflight_addr} into FIFO; if discard=1, drop data and clear discard; next state REQ.
REQ-021 At most one outstanding request; no request issued in WAIT.
REQ-022 FIFO full (count 2): no new request issued; an rvalid always finds space (guaranteed by REQ-017).
REQ-023 instr_valid_o = FIFO non-empty; instr_o/instr_addr_o = FIFO head; head stable while instr_valid_o & !instr_ready_i.
REQ-024 Push and pop in same cycle: count unchanged, order preserved; best case sustained throughput 1 instr per 2 cycles with 1-cycle memory latency is acceptable; no combinational path from imem_rvalid_i to instr_valid_o (latency rvalid -> instr_valid_o = 1 cycle).
REQ-025 jump_i=1: FIFO flushed (instr_valid_o=0 next cycle, any same-cycle pop ignored); pc <= {jump_target_i[31:2],2'b00}.
REQ-026 jump_i with request in flight (WAIT without rvalid) or held/granted in REQ: discard <= 1 so that response is dropped.
REQ-027 jump_i same cycle as rvalid in WAIT: data dropped, discard stays 0, go REQ.
REQ-028 jump_i overrides pc+4 increment when coincident with gnt.
REQ-029 Back-to-back jump_i: last target wins; at most one response discarded per outstanding request.
REQ-030 imem_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-031 rst_n low (asynchronous): state IDLE, pc=BOOT_ADDR, FIFO empty, discard=0, imem_req_o=0, imem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_addr_o=0.
REQ-032 Reset asserted mid-transaction: in-flight response after release ignored (state IDLE/REQ, REQ-030); first request at BOOT_ADDR.

Verification
REQ-033 Reset release, memory gnt same cycle, rvalid next cycle data 32'h0000_0013 -> imem_addr_o=0, then 4, 8; instr_o=32'h13, instr_addr_o=0 one cycle after rvalid.
REQ-034 instr_ready_i=0 for 10 cycles -> FIFO holds addr 0 and 4, imem_req_o=0, head stable; ready=1 -> instr_addr_o 0 then 4, fetch resumes at 8.
REQ-035 gnt delayed 3 cycles while jump_i to 32'h100 in cycle 1 -> imem_addr_o held at old pc until gnt, that response dropped, next request 32'h100, instr_addr_o=32'h100.
REQ-036 jump_i to 32'h203 same cycle as rvalid -> data dropped, next imem_addr_o=32'h200, FIFO empty next cycle.
REQ-037 BOOT_ADDR=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-038 rst_n pulsed low while in WAIT, rvalid arrives after release -> no push, instr_valid_o=0, first request at BOOT_ADDR.
